// File: rtl/fw_operand_select_if.sv
// Forwarding-bus / issue / operand-output bundle for fw_operand_select.
// master = pipeline side driving the bus and issue request, slave = the operand selector.
interface fw_operand_select_if #(
  parameter int STAGES = 7
);
  logic [STAGES-1:0]     st_regwr;
  logic [STAGES*7-1:0]   st_target;
  logic [STAGES*128-1:0] st_value;
  logic [STAGES*4-1:0]   st_fwstage;

  logic                  issue_valid;
  logic                  issue_ready;
  logic [6:0]            ra;
  logic [6:0]            rb;
  logic [6:0]            rc;
  logic [127:0]          rf_a;
  logic [127:0]          rf_b;
  logic [127:0]          rf_c;

  logic                  op_valid;
  logic [127:0]          op_a;
  logic [127:0]          op_b;
  logic [127:0]          op_c;
  logic                  stall_active;
  logic [15:0]           stall_cycles;
  logic                  stall_err;

  modport master (
    output st_regwr, st_target, st_value, st_fwstage,
    output issue_valid, ra, rb, rc, rf_a, rf_b, rf_c,
    input  issue_ready, op_valid, op_a, op_b, op_c,
    input  stall_active, stall_cycles, stall_err
  );

  modport slave (
    input  st_regwr, st_target, st_value, st_fwstage,
    input  issue_valid, ra, rb, rc, rf_a, rf_b, rf_c,
    output issue_ready, op_valid, op_a, op_b, op_c,
    output stall_active, stall_cycles, stall_err
  );
endinterface

// File: rtl/fw_operand_select.sv
// Resolves RA/RB/RC from the youngest in-flight producer or the register file,
// stalls issue while that producer's value is not yet available, registers operands.
//
// state | meaning
// IDLE  | no hazard last cycle; issuing normally
// STALL | issuing instruction blocked by a not-yet-ready youngest producer
module fw_operand_select #(
  parameter int STAGES      = 7,
  parameter int FIRST_STAGE = 2,
  parameter int MAX_STALL   = 31
) (
  input  logic               clock,
  input  logic               reset,
  fw_operand_select_if.slave bus
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);

  state_t           state;
  state_t           state_next;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_inc;
  logic [RUN_W-1:0] run_next;
  logic             run_exceed;

  logic             op_valid;
  logic [127:0]     op_reg [3];
  logic [15:0]      stall_cycles;
  logic             stall_err;

  logic [6:0]       src_addr [3];
  logic [127:0]     src_rf   [3];
  logic [127:0]     res_val  [3];
  logic             res_haz  [3];

  logic             hazard;
  logic             accept;

  assign src_addr[0] = bus.ra;
  assign src_addr[1] = bus.rb;
  assign src_addr[2] = bus.rc;
  assign src_rf[0]   = bus.rf_a;
  assign src_rf[1]   = bus.rf_b;
  assign src_rf[2]   = bus.rf_c;

  // Scan oldest to youngest so the youngest matching producer overwrites older ones.
  always_comb begin
    for (int o = 0; o < 3; o++) begin
      res_val[o] = src_rf[o];
      res_haz[o] = 1'b0;
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (bus.st_regwr[k] && (bus.st_target[7*k +: 7] == src_addr[o])) begin
          if (bus.st_fwstage[4*k +: 4] <= 4'(k + FIRST_STAGE)) begin
            res_val[o] = bus.st_value[128*k +: 128];
            res_haz[o] = 1'b0;
          end else begin
            res_val[o] = src_rf[o];
            res_haz[o] = 1'b1;
          end
        end
      end
    end
  end

  assign hazard          = bus.issue_valid & (res_haz[0] | res_haz[1] | res_haz[2]);
  assign bus.issue_ready = reset & ~hazard;
  assign accept          = bus.issue_valid & bus.issue_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hazard)  state_next = STALL;
      STALL:   if (!hazard) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A fresh stall starts the run at 1; run_exceed flags the step past MAX_STALL.
  always_comb begin
    run_inc    = (state == STALL) ? run_cnt : '0;
    run_exceed = (run_inc >= RUN_MAX);
    run_next   = (run_inc == RUN_SAT) ? RUN_SAT : run_inc + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      run_cnt      <= '0;
      op_valid     <= 1'b0;
      op_reg[0]    <= '0;
      op_reg[1]    <= '0;
      op_reg[2]    <= '0;
      stall_cycles <= '0;
      stall_err    <= 1'b0;
    end else begin
      state    <= state_next;
      op_valid <= accept;
      if (accept) begin
        op_reg[0] <= res_val[0];
        op_reg[1] <= res_val[1];
        op_reg[2] <= res_val[2];
      end
      if (hazard) begin
        run_cnt <= run_next;
        if (run_exceed) stall_err <= 1'b1;
        if (stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      end else begin
        run_cnt <= '0;
      end
    end
  end

  assign bus.op_valid     = op_valid;
  assign bus.op_a         = op_reg[0];
  assign bus.op_b         = op_reg[1];
  assign bus.op_c         = op_reg[2];
  assign bus.stall_active = (state == STALL);
  assign bus.stall_cycles = stall_cycles;
  assign bus.stall_err    = stall_err;

endmodule

// File: tb/tb_fw_operand_select.sv
// Directed + random bench for fw_operand_select against a per-cycle behavioural model.
module tb_fw_operand_select;
  localparam int STAGES = 7;
  localparam int FIRST  = 2;
  localparam int MAXS   = 31;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fw_operand_select_if #(.STAGES(STAGES)) bus ();

  fw_operand_select #(.STAGES(STAGES), .FIRST_STAGE(FIRST), .MAX_STALL(MAXS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Stimulus state
  logic         s_wr  [STAGES];
  logic [6:0]   s_tg  [STAGES];
  logic [127:0] s_val [STAGES];
  logic [3:0]   s_fw  [STAGES];
  logic         valid;
  logic [6:0]   addr  [3];
  logic [127:0] rf    [3];

  // Model state
  bit           m_valid;
  logic [127:0] m_op [3];
  int           m_run;
  bit           m_err;
  int           m_sc;

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < STAGES; k++) begin
      bus.st_regwr[k]           = s_wr[k];
      bus.st_target[7*k +: 7]   = s_tg[k];
      bus.st_value[128*k +: 128] = s_val[k];
      bus.st_fwstage[4*k +: 4]  = s_fw[k];
    end
    bus.issue_valid = valid;
    bus.ra = addr[0]; bus.rb = addr[1]; bus.rc = addr[2];
    bus.rf_a = rf[0]; bus.rf_b = rf[1]; bus.rf_c = rf[2];
  endtask

  // Youngest producer first: stop at the first matching stage.
  function automatic void resolve(input int o, output logic [127:0] v, output bit hz);
    int  k;
    bit  found;
    v = rf[o]; hz = 0; found = 0; k = 0;
    while (!found && k < STAGES) begin
      if (s_wr[k] && s_tg[k] == addr[o]) begin
        found = 1;
        if (int'(s_fw[k]) <= k + FIRST) v = s_val[k];
        else hz = 1;
      end
      k++;
    end
  endfunction

  task automatic clear_stages();
    for (int k = 0; k < STAGES; k++) begin
      s_wr[k] = 0; s_tg[k] = 7'(k + 100); s_val[k] = rnd128(); s_fw[k] = 4'd0;
    end
  endtask

  task automatic shift_bus();
    for (int k = STAGES - 1; k > 0; k--) begin
      s_wr[k] = s_wr[k-1]; s_tg[k] = s_tg[k-1]; s_val[k] = s_val[k-1]; s_fw[k] = s_fw[k-1];
    end
    s_wr[0] = 0; s_tg[0] = 7'd127; s_val[0] = rnd128(); s_fw[0] = 4'd0;
  endtask

  task automatic step();
    logic [127:0] v [3];
    bit           h [3];
    bit           hz;
    int           nxt;
    apply();
    #1;
    for (int o = 0; o < 3; o++) resolve(o, v[o], h[o]);
    hz = valid && (h[0] || h[1] || h[2]);
    check("issue_ready", bus.issue_ready, reset && !hz);
    @(posedge clock);
    #1;
    if (!reset) begin
      m_valid = 0; m_run = 0; m_err = 0; m_sc = 0;
      for (int o = 0; o < 3; o++) m_op[o] = '0;
    end else begin
      m_valid = valid && !hz;
      if (m_valid) for (int o = 0; o < 3; o++) m_op[o] = v[o];
      if (hz) begin
        nxt = m_run + 1;
        if (nxt > MAXS) m_err = 1;
        m_run = (nxt > MAXS + 1) ? MAXS + 1 : nxt;
        if (m_sc < 65535) m_sc++;
      end else begin
        m_run = 0;
      end
    end
    check("op_valid", bus.op_valid, m_valid);
    check("op_a", bus.op_a, m_op[0]);
    check("op_b", bus.op_b, m_op[1]);
    check("op_c", bus.op_c, m_op[2]);
    check("stall_active", bus.stall_active, m_run > 0);
    check("stall_cycles", bus.stall_cycles, 16'(m_sc));
    check("stall_err", bus.stall_err, m_err);
  endtask

  initial begin
    int sc0;
    m_valid = 0; m_run = 0; m_err = 0; m_sc = 0;
    for (int o = 0; o < 3; o++) m_op[o] = '0;
    clear_stages();
    valid = 0;
    addr[0] = 7'd5; addr[1] = 7'd6; addr[2] = 7'd7;
    for (int o = 0; o < 3; o++) rf[o] = rnd128();
    reset = 0;
    apply();
    @(posedge clock); #1;
    step();
    step();
    reset = 1;

    // No matches: register-file values issue
    valid = 1;
    step();

    // Youngest of two ready producers wins
    addr[0] = 7'd9;
    s_wr[0] = 1; s_tg[0] = 7'd9; s_fw[0] = 4'd2; s_val[0] = rnd128();
    s_wr[3] = 1; s_tg[3] = 7'd9; s_fw[3] = 4'd2; s_val[3] = rnd128();
    step();
    check("t2_youngest", bus.op_a, s_val[0]);

    // Same register on all three sources
    addr[1] = 7'd9; addr[2] = 7'd9;
    step();

    // Not-ready producer advancing down the bus: 4 stall cycles then issue
    clear_stages();
    addr[0] = 7'd1; addr[1] = 7'd12; addr[2] = 7'd3;
    s_wr[0] = 1; s_tg[0] = 7'd12; s_fw[0] = 4'd6; s_val[0] = rnd128();
    sc0 = m_sc;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 4) shift_bus();
    end
    check("t3_stall_cycles", bus.stall_cycles, 16'(sc0 + 4));
    check("t3_op_b", bus.op_b, s_val[4]);
    step();

    // Dropping issue_valid while stalled returns to idle
    clear_stages();
    s_wr[0] = 1; s_tg[0] = addr[0]; s_fw[0] = 4'd9;
    step();
    valid = 0;
    step();
    valid = 1;

    // Hazard held for 32 cycles latches stall_err
    clear_stages();
    addr[0] = 7'd20;
    s_wr[0] = 1; s_tg[0] = 7'd20; s_fw[0] = 4'd15;
    for (int i = 1; i <= 34; i++) begin
      step();
      if (i == 31) check("t4_err_before", bus.stall_err, 1'b0);
      if (i == 32) check("t4_err_set", bus.stall_err, 1'b1);
    end
    s_wr[0] = 0;
    step();
    check("t4_err_sticky", bus.stall_err, 1'b1);

    // Reset in the middle of a stall
    s_wr[0] = 1;
    step();
    step();
    reset = 0;
    step();
    check("t5_err_cleared", bus.stall_err, 1'b0);
    reset = 1;
    step();

    // Disabled write port with matching target is ignored
    clear_stages();
    s_wr[0] = 0; s_tg[0] = addr[0]; s_fw[0] = 4'd0; s_val[0] = rnd128();
    rf[0] = rnd128();
    step();
    check("t6_rf_used", bus.op_a, rf[0]);

    // Random traffic over a small register window
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < STAGES; k++) begin
        s_wr[k]  = ($urandom_range(0, 3) != 0);
        s_tg[k]  = 7'($urandom_range(0, 7));
        s_val[k] = rnd128();
        s_fw[k]  = 4'($urandom_range(0, 9));
      end
      for (int o = 0; o < 3; o++) begin
        addr[o] = 7'($urandom_range(0, 9));
        rf[o]   = rnd128();
      end
      valid = ($urandom_range(0, 7) != 0);
      reset = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
